// File: rtl/wb_port_arbiter_if.sv
// Bundle of the two result-producer handshakes, the register-file write port
// and the decode-facing status outputs of the writeback arbiter.
interface wb_port_arbiter_if #(
  parameter int XLEN  = 64,
  parameter int SEQ_W = 4
);
  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [XLEN-1:0]  alu_value;
  logic [SEQ_W-1:0] alu_seq;
  logic             alu_ready;

  logic             mem_valid;
  logic [4:0]       mem_rd;
  logic [XLEN-1:0]  mem_value;
  logic [SEQ_W-1:0] mem_seq;
  logic             mem_ready;

  logic             wb_en;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_value;
  logic [31:0]      busy_mask;
  logic [15:0]      conflict_cnt;

  modport master (
    output alu_valid, alu_rd, alu_value, alu_seq,
    input  alu_ready,
    output mem_valid, mem_rd, mem_value, mem_seq,
    input  mem_ready,
    input  wb_en, wb_rd, wb_value, busy_mask, conflict_cnt
  );

  modport slave (
    input  alu_valid, alu_rd, alu_value, alu_seq,
    output alu_ready,
    input  mem_valid, mem_rd, mem_value, mem_seq,
    output mem_ready,
    output wb_en, wb_rd, wb_value, busy_mask, conflict_cnt
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the ALU and load return paths,
// retiring queued results oldest-first by wrap-aware sequence tag.
module wb_port_arbiter #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int SEQ_W = 4
) (
  input  logic              CLK,
  input  logic              reset,
  wb_port_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]       alu_rd_q  [DEPTH];
  logic [XLEN-1:0]  alu_val_q [DEPTH];
  logic [SEQ_W-1:0] alu_seq_q [DEPTH];
  logic [PTR_W-1:0] alu_wp, alu_rp;
  logic [CNT_W-1:0] alu_cnt;

  logic [4:0]       mem_rd_q  [DEPTH];
  logic [XLEN-1:0]  mem_val_q [DEPTH];
  logic [SEQ_W-1:0] mem_seq_q [DEPTH];
  logic [PTR_W-1:0] mem_wp, mem_rp;
  logic [CNT_W-1:0] mem_cnt;

  logic             alu_push, mem_push, alu_pop, mem_pop;
  logic             alu_head_v, mem_head_v;
  logic [SEQ_W-1:0] age_d;
  logic [4:0]       pop_rd;
  logic [XLEN-1:0]  pop_value;
  logic [31:0]      busy;

  logic             wb_en_q;
  logic [4:0]       wb_rd_q;
  logic [XLEN-1:0]  wb_value_q;
  logic [15:0]      conflict_q;

  assign bus.alu_ready    = reset && (alu_cnt < CNT_W'(DEPTH));
  assign bus.mem_ready    = reset && (mem_cnt < CNT_W'(DEPTH));
  assign alu_push         = bus.alu_valid && bus.alu_ready;
  assign mem_push         = bus.mem_valid && bus.mem_ready;
  assign bus.wb_en        = wb_en_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_value     = wb_value_q;
  assign bus.busy_mask    = busy;
  assign bus.conflict_cnt = conflict_q;

  // Negative modular distance means the ALU head was issued first; ties go to mem.
  always_comb begin
    alu_head_v = (alu_cnt != '0);
    mem_head_v = (mem_cnt != '0);
    age_d      = alu_seq_q[alu_rp] - mem_seq_q[mem_rp];
    alu_pop    = alu_head_v && (!mem_head_v || age_d[SEQ_W-1]);
    mem_pop    = mem_head_v && !alu_pop;
    pop_rd     = alu_pop ? alu_rd_q[alu_rp]  : mem_rd_q[mem_rp];
    pop_value  = alu_pop ? alu_val_q[alu_rp] : mem_val_q[mem_rp];
  end

  always_comb begin
    busy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < alu_cnt) busy[alu_rd_q[alu_rp + PTR_W'(k)]] = 1'b1;
      if (CNT_W'(k) < mem_cnt) busy[mem_rd_q[mem_rp + PTR_W'(k)]] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (alu_push) begin
      alu_rd_q[alu_wp]  <= bus.alu_rd;
      alu_val_q[alu_wp] <= bus.alu_value;
      alu_seq_q[alu_wp] <= bus.alu_seq;
    end
    if (mem_push) begin
      mem_rd_q[mem_wp]  <= bus.mem_rd;
      mem_val_q[mem_wp] <= bus.mem_value;
      mem_seq_q[mem_wp] <= bus.mem_seq;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      alu_wp     <= '0;
      alu_rp     <= '0;
      alu_cnt    <= '0;
      mem_wp     <= '0;
      mem_rp     <= '0;
      mem_cnt    <= '0;
      wb_en_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_value_q <= '0;
      conflict_q <= '0;
    end else begin
      if (alu_push) alu_wp <= alu_wp + PTR_W'(1);
      if (alu_pop)  alu_rp <= alu_rp + PTR_W'(1);
      if (mem_push) mem_wp <= mem_wp + PTR_W'(1);
      if (mem_pop)  mem_rp <= mem_rp + PTR_W'(1);

      case ({alu_push, alu_pop})
        2'b10:   alu_cnt <= alu_cnt + CNT_W'(1);
        2'b01:   alu_cnt <= alu_cnt - CNT_W'(1);
        default: alu_cnt <= alu_cnt;
      endcase
      case ({mem_push, mem_pop})
        2'b10:   mem_cnt <= mem_cnt + CNT_W'(1);
        2'b01:   mem_cnt <= mem_cnt - CNT_W'(1);
        default: mem_cnt <= mem_cnt;
      endcase

      // x0 results retire silently and leave the previous write visible.
      if ((alu_pop || mem_pop) && pop_rd != 5'd0) begin
        wb_en_q    <= 1'b1;
        wb_rd_q    <= pop_rd;
        wb_value_q <= pop_value;
      end else begin
        wb_en_q    <= 1'b0;
      end

      if (alu_head_v && mem_head_v && conflict_q != 16'hFFFF)
        conflict_q <= conflict_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: ordering, tag wrap, backpressure,
// x0 beats and mid-operation reset.
module tb_wb_port_arbiter;
  logic CLK   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  wb_port_arbiter_if #(.XLEN(64), .SEQ_W(4)) bus ();

  wb_port_arbiter #(.XLEN(64), .DEPTH(2), .SEQ_W(4)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_value = '0; bus.alu_seq = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_value = '0; bus.mem_seq = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [63:0] v, input logic [3:0] s);
    bus.alu_valid = 1'b1; bus.alu_rd = rd; bus.alu_value = v; bus.alu_seq = s;
  endtask

  task automatic drive_mem(input logic [4:0] rd, input logic [63:0] v, input logic [3:0] s);
    bus.mem_valid = 1'b1; bus.mem_rd = rd; bus.mem_value = v; bus.mem_seq = s;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.alu_ready !== 1'b0) begin n_bad++; $display("FAIL rst_alu_ready got %0b want 0", bus.alu_ready); end
    n_cmp++; if (bus.mem_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mem_ready got %0b want 0", bus.mem_ready); end
    n_cmp++; if (bus.wb_en !== 1'b0) begin n_bad++; $display("FAIL rst_wb_en got %0b want 0", bus.wb_en); end
    n_cmp++; if (bus.wb_rd !== 5'd0) begin n_bad++; $display("FAIL rst_wb_rd got %0d want 0", bus.wb_rd); end
    n_cmp++; if (bus.wb_value !== 64'd0) begin n_bad++; $display("FAIL rst_wb_value got %0h want 0", bus.wb_value); end
    n_cmp++; if (bus.busy_mask !== 32'd0) begin n_bad++; $display("FAIL rst_busy got %0h want 0", bus.busy_mask); end
    n_cmp++; if (bus.conflict_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_conflict got %0d want 0", bus.conflict_cnt); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.alu_ready !== 1'b1) begin n_bad++; $display("FAIL rel_alu_ready got %0b want 1", bus.alu_ready); end
    n_cmp++; if (bus.mem_ready !== 1'b1) begin n_bad++; $display("FAIL rel_mem_ready got %0b want 1", bus.mem_ready); end
  endtask

  task automatic test_single();
    drive_alu(5'd5, 64'h1234, 4'd0);
    #1;
    n_cmp++; if (bus.alu_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready got %0b want 1", bus.alu_ready); end
    tick();
    idle();
    n_cmp++; if (bus.busy_mask !== 32'h20) begin n_bad++; $display("FAIL single_busy_q got %0h want 20", bus.busy_mask); end
    n_cmp++; if (bus.wb_en !== 1'b0) begin n_bad++; $display("FAIL single_en_early got %0b want 0", bus.wb_en); end
    tick();
    n_cmp++; if (bus.wb_en !== 1'b1) begin n_bad++; $display("FAIL single_en got %0b want 1", bus.wb_en); end
    n_cmp++; if (bus.wb_rd !== 5'd5) begin n_bad++; $display("FAIL single_rd got %0d want 5", bus.wb_rd); end
    n_cmp++; if (bus.wb_value !== 64'h1234) begin n_bad++; $display("FAIL single_value got %0h want 1234", bus.wb_value); end
    n_cmp++; if (bus.busy_mask !== 32'h0) begin n_bad++; $display("FAIL single_busy_clr got %0h want 0", bus.busy_mask); end
    tick();
    n_cmp++; if (bus.wb_en !== 1'b0) begin n_bad++; $display("FAIL single_en_drop got %0b want 0", bus.wb_en); end
  endtask

  task automatic test_same_edge();
    drive_alu(5'd7, 64'hA, 4'd3);
    drive_mem(5'd7, 64'hB, 4'd2);
    tick();
    idle();
    n_cmp++; if (bus.busy_mask !== 32'h80) begin n_bad++; $display("FAIL same_busy got %0h want 80", bus.busy_mask); end
    tick();
    n_cmp++; if (bus.wb_en !== 1'b1 || bus.wb_value !== 64'hB) begin n_bad++; $display("FAIL same_first got en=%0b val=%0h want en=1 val=b", bus.wb_en, bus.wb_value); end
    n_cmp++; if (bus.conflict_cnt !== 16'd1) begin n_bad++; $display("FAIL same_conflict got %0d want 1", bus.conflict_cnt); end
    tick();
    n_cmp++; if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd7 || bus.wb_value !== 64'hA) begin n_bad++; $display("FAIL same_second got en=%0b rd=%0d val=%0h want en=1 rd=7 val=a", bus.wb_en, bus.wb_rd, bus.wb_value); end
    n_cmp++; if (bus.conflict_cnt !== 16'd1) begin n_bad++; $display("FAIL same_conflict_hold got %0d want 1", bus.conflict_cnt); end
    tick();
  endtask

  task automatic test_tag_wrap();
    drive_alu(5'd3, 64'h30, 4'd0);
    drive_mem(5'd4, 64'h40, 4'd15);
    tick();
    idle();
    tick();
    n_cmp++; if (bus.wb_rd !== 5'd4 || bus.wb_value !== 64'h40) begin n_bad++; $display("FAIL wrap_first got rd=%0d val=%0h want rd=4 val=40", bus.wb_rd, bus.wb_value); end
    tick();
    n_cmp++; if (bus.wb_rd !== 5'd3 || bus.wb_value !== 64'h30) begin n_bad++; $display("FAIL wrap_second got rd=%0d val=%0h want rd=3 val=30", bus.wb_rd, bus.wb_value); end
    n_cmp++; if (bus.conflict_cnt !== 16'd2) begin n_bad++; $display("FAIL wrap_conflict got %0d want 2", bus.conflict_cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  m_rd  [3] = '{5'd10, 5'd11, 5'd12};
    logic [63:0] m_val [3] = '{64'h1008, 64'h1009, 64'h100A};
    logic [3:0]  m_seq [3] = '{4'd8, 4'd9, 4'd10};
    logic        exp_mr [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        exp_en [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [4:0]  exp_rd [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd10, 5'd11, 5'd12};
    logic [63:0] exp_v  [8] = '{64'h0, 64'h104, 64'h105, 64'h106, 64'h107, 64'h1008, 64'h1009, 64'h100A};
    int midx = 0;
    logic acc;
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c < 4) drive_alu(5'(c + 1), 64'h104 + 64'(c), 4'(4 + c));
      if (midx < 3) drive_mem(m_rd[midx], m_val[midx], m_seq[midx]);
      if (c < 7) begin
        n_cmp++; if (bus.mem_ready !== exp_mr[c]) begin n_bad++; $display("FAIL b2b_mem_ready c=%0d got %0b want %0b", c, bus.mem_ready, exp_mr[c]); end
      end
      acc = bus.mem_valid && bus.mem_ready;
      tick();
      if (acc) midx++;
      n_cmp++; if (bus.wb_en !== exp_en[c]) begin n_bad++; $display("FAIL b2b_en c=%0d got %0b want %0b", c, bus.wb_en, exp_en[c]); end
      if (exp_en[c]) begin
        n_cmp++; if (bus.wb_rd !== exp_rd[c] || bus.wb_value !== exp_v[c]) begin n_bad++; $display("FAIL b2b_wb c=%0d got rd=%0d val=%0h want rd=%0d val=%0h", c, bus.wb_rd, bus.wb_value, exp_rd[c], exp_v[c]); end
      end
      if (c == 4) begin
        n_cmp++; if (bus.busy_mask !== 32'h0C00) begin n_bad++; $display("FAIL b2b_busy got %0h want c00", bus.busy_mask); end
      end
    end
    idle();
    n_cmp++; if (midx !== 3) begin n_bad++; $display("FAIL b2b_accepts got %0d want 3", midx); end
    n_cmp++; if (bus.conflict_cnt !== 16'd6) begin n_bad++; $display("FAIL b2b_conflict got %0d want 6", bus.conflict_cnt); end
  endtask

  task automatic test_rd_zero();
    drive_alu(5'd0, 64'hFF, 4'd11);
    tick();
    idle();
    n_cmp++; if (bus.busy_mask !== 32'h0) begin n_bad++; $display("FAIL x0_busy got %0h want 0", bus.busy_mask); end
    tick();
    n_cmp++; if (bus.wb_en !== 1'b0) begin n_bad++; $display("FAIL x0_en got %0b want 0", bus.wb_en); end
    n_cmp++; if (bus.wb_rd !== 5'd12 || bus.wb_value !== 64'h100A) begin n_bad++; $display("FAIL x0_hold got rd=%0d val=%0h want rd=12 val=100a", bus.wb_rd, bus.wb_value); end
    n_cmp++; if (bus.alu_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ready got %0b want 1", bus.alu_ready); end
  endtask

  task automatic test_reset_mid();
    drive_alu(5'd6, 64'h66, 4'd12);
    drive_mem(5'd9, 64'h99, 4'd13);
    tick();
    idle();
    n_cmp++; if (bus.busy_mask !== 32'h240) begin n_bad++; $display("FAIL mid_busy got %0h want 240", bus.busy_mask); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready_low got %0b%0b want 00", bus.alu_ready, bus.mem_ready); end
    tick();
    n_cmp++; if (bus.wb_en !== 1'b0) begin n_bad++; $display("FAIL mid_en got %0b want 0", bus.wb_en); end
    n_cmp++; if (bus.busy_mask !== 32'h0) begin n_bad++; $display("FAIL mid_busy_clr got %0h want 0", bus.busy_mask); end
    n_cmp++; if (bus.wb_rd !== 5'd0 || bus.wb_value !== 64'd0) begin n_bad++; $display("FAIL mid_wb got rd=%0d val=%0h want 0 0", bus.wb_rd, bus.wb_value); end
    n_cmp++; if (bus.conflict_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_conflict got %0d want 0", bus.conflict_cnt); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_rel got %0b%0b want 11", bus.alu_ready, bus.mem_ready); end
    tick();
    n_cmp++; if (bus.wb_en !== 1'b0) begin n_bad++; $display("FAIL mid_no_pulse1 got %0b want 0", bus.wb_en); end
    tick();
    n_cmp++; if (bus.wb_en !== 1'b0) begin n_bad++; $display("FAIL mid_no_pulse2 got %0b want 0", bus.wb_en); end
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_same_edge();
    test_tag_wrap();
    test_back_to_back();
    test_rd_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port (wb_rd / wb_value / wb_en into the decode stage) between two result producers: the ALU result path and the load/memory return path.
- Each source feeds a small per-source FIFO. A wrap-aware age comparison on instruction sequence tags retires results in program order, so a late load cannot overwrite a younger ALU result to the same rd.
- Publishes a pending-destination mask that the decode stage uses for stall decisions.

Parameters:
- XLEN, 64, data width of results and wb_value.
- DEPTH, 2, entries per source FIFO; power of two, at least 2.
- SEQ_W, 4, sequence tag width; at most 2^(SEQ_W-1) instructions may be in flight.

Ports:
- CLK  input  1  rising-edge clock
- reset  input  1  synchronous active-low reset, sampled on rising CLK
- alu_valid  input  1  ALU result offered
- alu_rd  input  5  ALU destination register
- alu_value  input  XLEN  ALU result
- alu_seq  input  SEQ_W  program-order tag of the ALU result
- alu_ready  output  1  ALU FIFO can accept
- mem_valid  input  1  load result offered
- mem_rd  input  5  load destination register
- mem_value  input  XLEN  load data, already sign/zero extended
- mem_seq  input  SEQ_W  program-order tag of the load
- mem_ready  output  1  memory FIFO can accept
- wb_en  output  1  register-file write strobe, registered
- wb_rd  output  5  write index, registered
- wb_value  output  XLEN  write data, registered
- busy_mask  output  32  bit r set while a result for xr sits in either FIFO
- conflict_cnt  output  16  saturating count of cycles with both FIFO heads valid

Behaviour:
- Reset (reset=0 at a rising edge):
  - Both FIFOs empty, pointers 0.
  - wb_en=0, wb_rd=0, wb_value=0, conflict_cnt=0.
  - alu_ready and mem_ready are forced 0 while reset is low. busy_mask=0.
  - Reset mid-operation discards all queued results; no wb_en pulse is issued for them.
- Handshake:
  - A beat transfers on a rising edge where valid && ready.
  - x_ready = !reset_low && (count_x < DEPTH). Ready depends only on occupancy, never on x_valid.
  - A full FIFO that pops in the same cycle still shows ready=0; there is no same-cycle pass-through.
  - The source must hold its rd, value and seq stable while valid && !ready.
- FIFOs:
  - Circular buffers with read/write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
  - count is a separate (log2(DEPTH)+1)-bit counter.
  - Simultaneous push and pop leaves count unchanged.
- rd=0 beats: accepted normally, occupy a slot, and are popped in order. When selected they drive wb_en=0 and leave wb_rd/wb_value unchanged. They never set a busy_mask bit.
- Arbitration (combinational on FIFO heads, one pop per cycle):
  - Only one head valid: pop it.
  - Both heads valid: compute d = (alu_head_seq - mem_head_seq) mod 2^SEQ_W. If d[SEQ_W-1]=1 the ALU head is older and is popped; otherwise the mem head is popped. Equal tags pop the mem head.
  - Neither head valid: no pop, and wb_en=0 at the next edge.
- Writeback register: on the edge of a pop with rd!=0, wb_en=1, wb_rd=head rd, wb_value=head value. On any other edge wb_en=0.
- Latency: a beat accepted at edge k sits at the FIFO head after edge k. At the earliest it is written to wb_* at edge k+1, i.e. visible one cycle after acceptance. Throughput is one write per cycle.
- busy_mask: OR over all valid entries of both FIFOs of (1<<rd), with bit 0 forced 0. Computed combinationally from FIFO state. A result leaving the FIFO into the wb register clears its bit, because decode bypasses wb_value.
- conflict_cnt: increments on every edge where both heads are valid; it saturates at 16'hFFFF.
- Starvation: none. Tags are monotonic in program order, so the older head always drains first.

Test Plan:
- Reset, then a single ALU beat (rd=5, value=64'h1234, seq=0) -> alu_ready=1 throughout. One cycle after acceptance: wb_en=1, wb_rd=5, wb_value=64'h1234 for exactly one cycle. busy_mask[5] is set only while the beat is queued.
- Same-edge ALU (rd=7, seq=3, 64'hA) and mem (rd=7, seq=2, 64'hB) -> mem written first (wb_value=B), ALU next cycle (wb_value=A). Final x7=A. conflict_cnt=1.
- Tag wrap with SEQ_W=4: mem seq=15 and ALU seq=0 both queued -> mem pops first.
- Hold mem_valid with 3 beats while wb is not draining because an older ALU head keeps winning -> mem_ready=0 after 2 accepts (DEPTH=2). The third beat is held stable and accepted once count drops. All 3 values appear in order.
- ALU beat with rd=0 (value=64'hFF) -> accepted and popped, wb_en stays 0, busy_mask stays 0.
- Two queued entries, then reset low for one edge -> FIFOs empty, no wb_en pulse, busy_mask=0, both readies 0 during reset and 1 after it is released.
